// File: rtl/cv32e40p_tmr_fault_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cv32e40p_tmr_fault_monitor                                                 |
// | Timestamps TMR voter mismatches, counts them per source, buffers records   |
// | in a FIFO for a reader and raises a sticky alarm at a count threshold.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cv32e40p_tmr_fault_monitor #(
    parameter int N_SRC    = 3,
    parameter int DEPTH    = 4,
    parameter int TS_W     = 16,
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_i,
    input  logic [N_SRC-1:0]         faulty_i,
    input  logic                     clear_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [N_SRC+TS_W-1:0]    rec_data_o,
    output logic [N_SRC*CNT_W-1:0]   fault_cnt_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     overflow_o,
    output logic                     alarm_o,
    output logic [1:0]               state_o
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam int              c_REC_W    = N_SRC + TS_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_ALARM_TH = CNT_W'(ALARM_TH);

    localparam logic [1:0] c_ST_OK    = 2'd0;
    localparam logic [1:0] c_ST_FAULT = 2'd1;
    localparam logic [1:0] c_ST_ALARM = 2'd2;

    logic [TS_W-1:0]    r_ts;
    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt [N_SRC];
    logic [CNT_W-1:0]   w_cnt_nxt [N_SRC];
    logic [N_SRC-1:0]   w_hit;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_overflow;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic w_event, w_empty, w_full, w_pop, w_push, w_drop, w_alarm_trig;

    // Timestamp runs through soft clears so records stay globally ordered.
    always_ff @(posedge clk) begin
        if (rst) r_ts <= '0;
        else     r_ts <= r_ts + TS_W'(1);
    end

    assign w_event = sample_i && (|faulty_i);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && rec_ready_i;
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    assign rec_valid_o = !w_empty;
    assign rec_data_o  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
        end
    end

    // Push into a full FIFO only happens with a pop, when the write slot is the head being read out.
    always_ff @(posedge clk) begin
        if (!rst && !clear_i && w_push)
            r_mem[r_wr_ptr[c_AW-1:0]] <= {faulty_i, r_ts};
    end

    generate
        for (genvar k = 0; k < N_SRC; k++) begin : g_cnt
            assign w_cnt_nxt[k] = (w_event && faulty_i[k] && (r_cnt[k] != c_CNT_MAX)) ?
                                  r_cnt[k] + CNT_W'(1) : r_cnt[k];
            assign w_hit[k]     = (w_cnt_nxt[k] >= c_ALARM_TH);
            assign fault_cnt_o[k*CNT_W +: CNT_W] = r_cnt[k];

            always_ff @(posedge clk) begin
                if (rst || clear_i) r_cnt[k] <= '0;
                else                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            if (r_drop_cnt != c_CNT_MAX) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            r_overflow <= 1'b1;
        end
    end

    assign drop_cnt_o   = r_drop_cnt;
    assign overflow_o   = r_overflow;
    assign w_alarm_trig = w_event && (|w_hit);

    always_ff @(posedge clk) begin
        if (rst || clear_i) r_state <= c_ST_OK;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_OK: begin
                if (w_alarm_trig) w_state_nxt = c_ST_ALARM;
                else if (w_event) w_state_nxt = c_ST_FAULT;
            end
            c_ST_FAULT: begin
                if (w_alarm_trig) w_state_nxt = c_ST_ALARM;
            end
            c_ST_ALARM: w_state_nxt = c_ST_ALARM;
            default:    w_state_nxt = c_ST_OK;
        endcase
    end

    always_comb begin
        state_o = r_state;
        alarm_o = (r_state == c_ST_ALARM);
    end

endmodule
`default_nettype wire

// File: doc/cv32e40p_tmr_fault_monitor.md
Name: cv32e40p_tmr_fault_monitor

Overview:
- Consumer of the per-voter faulty flags produced by the TMR-protected units (ALU result, comparison and ready voters).
- Timestamps each mismatch event, keeps per-source saturating counters and buffers fault records in a small FIFO.
- Records are drained over a valid/ready read port by a debug or test-harness reader.
- Drives a sticky alarm to the controller once a threshold is reached.

Parameters:
- N_SRC, 3, number of voter faulty inputs monitored.
- DEPTH, 4, record FIFO depth; power of two, at least 2.
- TS_W, 16, timestamp counter width.
- CNT_W, 8, per-source fault counter width.
- ALARM_TH, 4, per-source count that raises the alarm; must be nonzero and at most 2^CNT_W-1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- sample_i  in  1  the faulty_i vector is qualified this cycle (tied to the unit enable).
- faulty_i  in  N_SRC  per-voter mismatch flags; bit k comes from voter k.
- clear_i  in  1  synchronous soft clear of FIFO, counters, flags and state.
- rec_valid_o  out  1  FIFO head record available.
- rec_ready_i  in  1  reader accepts the head record.
- rec_data_o  out  N_SRC+TS_W  head record {src_mask, timestamp}; src_mask in the MSBs.
- fault_cnt_o  out  N_SRC*CNT_W  packed per-source counters; source k at [k*CNT_W +: CNT_W].
- drop_cnt_o  out  CNT_W  number of records lost to a full FIFO.
- overflow_o  out  1  sticky: at least one record was dropped.
- alarm_o  out  1  sticky alarm.
- state_o  out  2  FSM state: 0 OK, 1 FAULT, 2 ALARM.

Behaviour:
- Reset (rst=1 at the clock edge):
  - FIFO empty, so rec_valid_o=0 and rec_data_o=0.
  - All counters 0, drop_cnt_o=0, overflow_o=0, alarm_o=0, state OK, timestamp 0.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps from 2^TS_W-1 to 0. It is not cleared by clear_i.
- Event: a cycle with sample_i=1 and faulty_i!=0.
  - Record = {faulty_i, current timestamp}, where timestamp is the value before that cycle's increment.
  - faulty_i with sample_i=0 is ignored. sample_i with faulty_i=0 is ignored.
- Push: an event pushes its record if the FIFO is not full.
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped.
  - On a drop, drop_cnt_o increments (saturating at all-ones) and overflow_o is set.
- Pop: occurs when rec_valid_o and rec_ready_i are both 1.
  - rec_data_o is the head record and is stable while rec_valid_o=1 and not popped.
  - Push and pop in the same cycle both succeed at any occupancy, including full. At empty, the new record appears the next cycle, never same-cycle.
- Latency: an event at edge N gives rec_valid_o=1 after edge N, when the FIFO was empty.
- Counters: for each source k with faulty_i[k]=1 in an event, fault_cnt[k] increments and saturates at 2^CNT_W-1. Counters update even when the record is dropped.
- FSM:
  - OK -> FAULT on the first event.
  - OK or FAULT -> ALARM when any counter's next value is at least ALARM_TH. OK goes straight to ALARM if ALARM_TH=1.
  - ALARM is held until clear_i or rst.
  - alarm_o=1 exactly when the state is ALARM, registered, so it asserts the cycle after the triggering event.
- clear_i: same effect as reset except for the timestamp.
  - clear_i has priority over a same-cycle event and a same-cycle pop; the event is lost and not counted.
- Reset mid-operation: rst overrides everything and empties the FIFO; records in flight are discarded without a handshake.
- rec_valid_o must not depend combinationally on rec_ready_i.

Test Plan:
- Reset, then idle 10 cycles: rec_valid_o=0, all counts 0, state_o=0, alarm_o=0.
- Single event at timestamp 5 with faulty_i=3'b010:
  - Next cycle rec_valid_o=1, rec_data_o={3'b010,16'd5}, fault_cnt[1]=1, state_o=1.
  - Pop with rec_ready_i=1, then rec_valid_o=0.
- Five back-to-back events with faulty_i=3'b001, no reader:
  - The FIFO holds the first 4 records; the 5th is dropped, so drop_cnt_o=1 and overflow_o=1.
  - fault_cnt[0]=5; alarm_o=1 from the cycle after the 4th event; state_o=2.
- FIFO full, with an event and rec_ready_i=1 in the same cycle: no drop, occupancy stays 4, and the new record is last in read order.
- State ALARM, assert clear_i together with an event:
  - Next cycle state_o=0, alarm_o=0, counters 0, rec_valid_o=0.
  - The timestamp keeps counting.
- Timestamp wrap with TS_W=4: events at ts 15 and then 0 yield records with ts 15 and then 0, in order.
- Hold rec_ready_i=0 with a record pending: rec_data_o is unchanged across 3 stall cycles.
